// File: rtl/digi_lock.sv
// digi_lock: four-digit keypad combination lock.
// A one-hot 10-key keypad enters decimal digits. With modo=1 the digits are
// shifted into the stored password; with modo=0 every group of four digits is
// compared against it, and a match opens the latch for OPEN_TIME cycles.
//
// Key handshake: there is no valid/ready pair on this block. A key "event" is
// the only transfer: it is accepted on a rising edge when codificador is
// exactly one-hot and differs from the value sampled on the previous edge.
// The block is always ready, so every event is consumed on the edge where it
// is first seen. The previous-key register samples every cycle, including
// all-zero and multi-bit values, so a held key yields a single event.
module digi_lock #(
  parameter int unsigned OPEN_TIME = 100000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [9:0]  codificador,
  input  logic        modo,
  output logic        fechadura,
  output logic        comparador,
  output logic [16:0] relogio
);

  localparam logic [16:0] OPEN_TIME_C = 17'(OPEN_TIME);

  // Password and entry are packed BCD, oldest digit in the top nibble.
  logic [15:0] pw_q, pw_d;
  logic [11:0] entry_q, entry_d;
  logic [1:0]  count_q, count_d;
  logic [9:0]  prev_key_q, prev_key_d;
  logic        modo_q, modo_d;
  logic        fech_q, fech_d;
  logic        comp_q, comp_d;
  logic [16:0] relogio_q, relogio_d;

  logic        key_onehot;
  logic        key_event;
  logic [3:0]  key_digit;
  logic        mode_change;
  logic [1:0]  count_base;
  logic        code_match;

  // Keypad decode: one-hot test, edge detection against the previous sample,
  // and index-to-BCD encoding of the pressed key.
  always_comb begin
    key_onehot = (codificador != 10'd0) &&
                 ((codificador & (codificador - 10'd1)) == 10'd0);
    key_event  = key_onehot && (codificador != prev_key_q);
    key_digit  = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (codificador[i]) key_digit = 4'(i);
    end
  end

  // Next-state logic. Program mode overrides everything; in verify mode the
  // fourth digit's comparison takes precedence over the countdown.
  always_comb begin
    pw_d        = pw_q;
    entry_d     = entry_q;
    count_d     = count_q;
    prev_key_d  = codificador;
    modo_d      = modo;
    fech_d      = fech_q;
    comp_d      = comp_q;
    relogio_d   = relogio_q;
    mode_change = (modo != modo_q);
    count_base  = mode_change ? 2'd0 : count_q;
    code_match  = ({entry_q, key_digit} == pw_q);

    if (modo) begin
      // Program mode: shift digits into the password and hold the latch shut.
      count_d   = 2'd0;
      fech_d    = 1'b0;
      comp_d    = 1'b0;
      relogio_d = 17'd0;
      if (key_event) begin
        pw_d = {pw_q[11:0], key_digit};
      end
    end else begin
      count_d = count_base;
      if (key_event && (count_base == 2'd3)) begin
        // Fourth digit: compare three stored digits plus the incoming one.
        count_d = 2'd0;
        comp_d  = code_match;
        if (code_match) begin
          fech_d    = 1'b1;
          relogio_d = OPEN_TIME_C;
        end else begin
          fech_d    = 1'b0;
          relogio_d = 17'd0;
        end
      end else begin
        if (key_event) begin
          entry_d = {entry_q[7:0], key_digit};
          count_d = count_base + 2'd1;
        end
        if (relogio_q != 17'd0) begin
          relogio_d = relogio_q - 17'd1;
          if (relogio_q == 17'd1) fech_d = 1'b0;
        end
      end
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pw_q       <= 16'd0;
      entry_q    <= 12'd0;
      count_q    <= 2'd0;
      prev_key_q <= 10'd0;
      modo_q     <= 1'b0;
      fech_q     <= 1'b0;
      comp_q     <= 1'b0;
      relogio_q  <= 17'd0;
    end else begin
      pw_q       <= pw_d;
      entry_q    <= entry_d;
      count_q    <= count_d;
      prev_key_q <= prev_key_d;
      modo_q     <= modo_d;
      fech_q     <= fech_d;
      comp_q     <= comp_d;
      relogio_q  <= relogio_d;
    end
  end

  assign fechadura  = fech_q;
  assign comparador = comp_q;
  assign relogio    = relogio_q;

endmodule

// File: tb/tb_digi_lock.sv
// Testbench for digi_lock: directed key sequences with hand-computed outputs.
// Driver steps push the expected {fechadura, comparador, relogio} for the edge
// they drive; a monitor pops and compares just after that edge.
module tb_digi_lock;

  localparam int OT = 8;

  logic        clock;
  logic        reset;
  logic [9:0]  codificador;
  logic        modo;
  logic        fechadura;
  logic        comparador;
  logic [16:0] relogio;

  logic [18:0] exp_q[$];
  string       name_q[$];
  int          checks;
  int          failures;

  digi_lock #(.OPEN_TIME(OT)) dut (
    .clock       (clock),
    .reset       (reset),
    .codificador (codificador),
    .modo        (modo),
    .fechadura   (fechadura),
    .comparador  (comparador),
    .relogio     (relogio)
  );

  // Clock and watchdog
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [9:0] key(input int d);
    logic [9:0] v;
    v = 10'd0;
    v[d] = 1'b1;
    return v;
  endfunction

  task automatic check(input string name, input logic [18:0] act, input logic [18:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got f=%0b c=%0b r=%0d, required f=%0b c=%0b r=%0d",
               name, act[18], act[17], act[16:0], exp[18], exp[17], exp[16:0]);
    end
  endtask

  // Driver: one clock step, optionally with an expected result for its edge.
  task automatic drive(input logic [9:0] code, input logic m, input bit chk,
                       input logic f, input logic c, input int r, input string name);
    @(negedge clock);
    codificador = code;
    modo        = m;
    if (chk) begin
      exp_q.push_back({f, c, 17'(r)});
      name_q.push_back(name);
    end
    @(posedge clock);
  endtask

  task automatic sn(input logic [9:0] code, input logic m);
    drive(code, m, 1'b0, 1'b0, 1'b0, 0, "");
  endtask

  task automatic sc(input logic [9:0] code, input logic m, input logic f,
                    input logic c, input int r, input string name);
    drive(code, m, 1'b1, f, c, r, name);
  endtask

  // Monitor / scoreboard
  initial begin
    logic [18:0] e;
    string       n;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        check(n, {fechadura, comparador, relogio}, e);
      end
    end
  end

  // Stimulus
  initial begin
    checks      = 0;
    failures    = 0;
    codificador = 10'd0;
    modo        = 1'b0;
    reset       = 1'b1;
    #2;
    check("reset_state", {fechadura, comparador, relogio}, 19'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Default password 0000 opens; countdown OT..0
    sn(key(0), 0); sn(0, 0); sn(key(0), 0); sn(0, 0); sn(key(0), 0); sn(0, 0);
    sc(key(0), 0, 1, 1, OT, "match_0000");
    for (int i = 1; i <= OT; i++) sc(0, 0, (OT - i) != 0, 1, OT - i, "countdown");
    sc(0, 0, 0, 1, 0, "comp_hold");

    // Program 0275 without releases, then verify
    sc(key(0), 1, 0, 0, 0, "prog_force");
    sn(key(2), 1); sn(key(7), 1); sn(key(5), 1);
    sn(0, 0);
    sn(key(0), 0); sn(key(2), 0); sn(key(7), 0);
    sc(key(5), 0, 1, 1, OT, "match_0275");
    sc(key(0), 0, 1, 1, OT - 1, "countdown_in_entry");
    sn(key(1), 0); sn(key(8), 0);
    sc(key(7), 0, 0, 0, 0, "mismatch_0187");
    sn(key(0), 0); sn(key(2), 0); sn(key(7), 0);
    sc(key(5), 0, 1, 1, OT, "match_0275_again");

    // Held key gives one event; 3333 fails against 0275
    for (int i = 0; i < 10; i++) sn(key(3), 0);
    sn(0, 0); sn(key(3), 0); sn(0, 0);
    sc(key(3), 0, 0, 1, 0, "no_early_compare");
    sn(0, 0);
    sc(key(3), 0, 0, 0, 0, "hold_3333_mismatch");

    // Program 3333, then the held-key sequence matches
    sc(0, 1, 0, 0, 0, "prog_force_again");
    for (int i = 0; i < 4; i++) begin
      sn(key(3), 1); sn(0, 1);
    end
    sn(0, 0);
    for (int i = 0; i < 10; i++) sn(key(3), 0);
    sn(0, 0); sn(key(3), 0); sn(0, 0); sn(key(3), 0); sn(0, 0);
    sc(key(3), 0, 1, 1, OT, "hold_3333_match");

    // Multi-bit and all-zero values never create events
    sn(10'h003, 0); sn(key(3), 0); sn(10'h003, 0); sn(key(3), 0); sn(0, 0);
    sc(key(3), 0, 1, 1, OT - 6, "multibit_mid");
    sc(10'h00C, 0, 1, 1, OT - 7, "multibit_no_event");
    sc(key(3), 0, 1, 1, OT, "multibit_ignored");

    // Program mode mid-entry clears the count and locks
    sn(key(0), 0); sn(key(1), 0);
    sc(0, 1, 0, 0, 0, "prog_mid_entry");
    sn(0, 0);
    sn(key(3), 0); sn(0, 0); sn(key(3), 0); sn(0, 0); sn(key(3), 0); sn(0, 0);
    sc(key(3), 0, 1, 1, OT, "count_cleared_match");

    // Successful attempt during unlock reloads the timer
    sn(0, 0); sn(key(3), 0); sn(0, 0); sn(key(3), 0); sn(0, 0); sn(key(3), 0);
    sc(0, 0, 1, 1, 1, "pre_reload");
    sc(key(3), 0, 1, 1, OT, "reload_match");

    // Failed attempt during unlock locks at once
    sn(key(1), 0); sn(key(2), 0);
    sc(key(4), 0, 1, 1, OT - 3, "pre_fail");
    sc(key(6), 0, 0, 0, 0, "fail_during_unlock");

    // Program mode during unlock locks
    sn(key(3), 0); sn(0, 0); sn(key(3), 0); sn(0, 0); sn(key(3), 0); sn(0, 0);
    sc(key(3), 0, 1, 1, OT, "unlock_again");
    sc(0, 1, 0, 0, 0, "prog_during_unlock");
    sn(0, 0);

    // Asynchronous reset mid-unlock, password reverts to 0000
    sn(key(3), 0); sn(0, 0); sn(key(3), 0); sn(0, 0); sn(key(3), 0); sn(0, 0);
    sc(key(3), 0, 1, 1, OT, "unlock_for_reset");
    @(posedge clock);
    #3;
    codificador = 10'd0;
    reset = 1'b1;
    #1;
    check("async_reset", {fechadura, comparador, relogio}, 19'd0);
    @(negedge clock);
    reset = 1'b0;
    sn(key(0), 0); sn(0, 0); sn(key(0), 0); sn(0, 0); sn(key(0), 0); sn(0, 0);
    sc(key(0), 0, 1, 1, OT, "password_reverted");

    repeat (3) @(negedge clock);
    check("queue_drain", 19'(exp_q.size()), 19'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
